// File: rtl/dcdata_wr_ctl.sv
// Write-port sequencer for the data-cache data array: linefill beats plus held store-hit writes.
// Optional store/beat merge for same-line stores during a reload is enabled by DCDATA_WR_MERGE_EN.
module dcdata_wr_ctl #(
  parameter int BEATS = 8,
  parameter int ADR_W = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rld_start,
  input  logic [ADR_W-$clog2(BEATS)-1:0]  rld_line,
  input  logic                            beat_val,
  input  logic [31:0]                     beat_dat,
  output logic                            beat_rdy,
  input  logic                            st_val,
  input  logic [ADR_W-1:0]                st_adr,
  input  logic [3:0]                      st_be,
  input  logic [31:0]                     st_dat,
  output logic                            st_rdy,
  output logic [3:0]                      wr_en,
  output logic [ADR_W-1:0]                wr_adr,
  output logic [31:0]                     wr_dat,
  output logic                            rld_busy,
  output logic                            rld_done
);

  localparam int CW = $clog2(BEATS);
  localparam int LW = ADR_W - CW;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic {IDLE = 1'b0, RELOAD = 1'b1} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [LW-1:0]    line;
  logic             hv;
  logic [ADR_W-1:0] h_adr;
  logic [3:0]       h_be;
  logic [31:0]      h_dat;

  logic beat_acc;
  logic st_acc;
  logic same_line;
  logic drain;
  logic merge;

  // Store bytes where enabled, beat bytes elsewhere.
  function automatic logic [31:0] merge_bytes(input logic [3:0] be,
                                              input logic [31:0] sd,
                                              input logic [31:0] bd);
    logic [31:0] r;
    r = bd;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = sd[8*i +: 8];
    end
    return r;
  endfunction

  assign beat_rdy  = (state == RELOAD);
  assign rld_busy  = (state == RELOAD);
  assign st_rdy    = !hv;
  assign beat_acc  = beat_val && (state == RELOAD);
  assign st_acc    = st_val && !hv;
  assign same_line = (h_adr[ADR_W-1:CW] == line);

`ifdef DCDATA_WR_MERGE_EN
  logic [CW-1:0] h_word;
  assign h_word = h_adr[CW-1:0];
`endif

  // Decide whether the held store drains alone or merges into this cycle's beat write.
  always_comb begin
    drain = 1'b0;
    merge = 1'b0;
    if (!hv) begin
      drain = 1'b0;
    end else if (state == IDLE) begin
      drain = 1'b1;
    end else if (!same_line) begin
      drain = !beat_acc;
    end else begin
`ifdef DCDATA_WR_MERGE_EN
      if (h_word < cnt) begin
        drain = !beat_acc;
      end else if (h_word == cnt) begin
        merge = beat_acc;
      end else begin
        drain = 1'b0;
      end
`else
      // Same-line store waits until the whole line has been filled.
      drain = 1'b0;
`endif
    end
  end

  // Reload sequencing, store hold register and the registered array write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      line     <= '0;
      hv       <= 1'b0;
      h_adr    <= '0;
      h_be     <= 4'h0;
      h_dat    <= 32'h0;
      wr_en    <= 4'h0;
      wr_adr   <= '0;
      wr_dat   <= 32'h0;
      rld_done <= 1'b0;
    end else begin
      rld_done <= 1'b0;
      wr_en    <= 4'h0;

      case (state)
        IDLE: begin
          if (rld_start) begin
            state <= RELOAD;
            line  <= rld_line;
            cnt   <= '0;
          end
        end
        RELOAD: begin
          if (beat_acc) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              state    <= IDLE;
              rld_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Beats own the port; a held store only takes it in a beat-free cycle.
      if (beat_acc) begin
        wr_en  <= 4'hF;
        wr_adr <= {line, cnt};
        wr_dat <= merge ? merge_bytes(h_be, h_dat, beat_dat) : beat_dat;
      end else if (drain) begin
        wr_en  <= h_be;
        wr_adr <= h_adr;
        wr_dat <= h_dat;
      end

      if (st_acc) begin
        hv    <= 1'b1;
        h_adr <= st_adr;
        h_be  <= st_be;
        h_dat <= st_dat;
      end else if (drain || merge) begin
        hv <= 1'b0;
      end
    end
  end

endmodule

// File: doc/dcdata_wr_ctl.md
# dcdata_wr_ctl

Write-port sequencer for the 1024-word, byte-lane data-cache data array. It turns two traffic sources into single-cycle array writes: linefill reload beats from the memory side, and store-hit byte writes from the LSU. It drives the array's `wr_en`/`wr_adr`/`wr_dat` directly from registers. It owns reload sequencing, store holding, and the ordering between stores and reloads to the same line.

## Interface
- `BEATS`, 8: 32-bit words per cache line; power of 2, at least 2.
- `ADR_W`, 10: array word-address width. Line index is `ADR_W-log2(BEATS)` bits (7 by default).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `rld_start` in 1: start reload; sampled only in IDLE.
- `rld_line` in `ADR_W-log2(BEATS)`: line index, captured with `rld_start`.
- `beat_val` in 1: reload beat valid.
- `beat_dat` in 32: reload beat data. Beats arrive word 0 first, in ascending order.
- `beat_rdy` out 1: beat accepted when `beat_val & beat_rdy`.
- `st_val` in 1: store request valid.
- `st_adr` in `ADR_W`: store word address.
- `st_be` in 4: store byte enables; bit n covers bits 8n+7:8n.
- `st_dat` in 32: store data.
- `st_rdy` out 1: store accepted when `st_val & st_rdy`.
- `wr_en` out 4: byte write enables to the array (registered).
- `wr_adr` out `ADR_W`: array write address (registered).
- `wr_dat` out 32: array write data (registered).
- `rld_busy` out 1: high while in RELOAD.
- `rld_done` out 1: one-cycle pulse, coincident with the last beat's write.

## Operation
- Two states, IDLE and RELOAD. A beat counter `cnt` (log2(BEATS) bits) indexes the word within the line. A one-entry store hold register `hv` holds address, byte enables and data.
- IDLE → RELOAD: on `rld_start`. Captures `rld_line` and clears `cnt` to 0. `rld_start` is ignored in RELOAD.
- RELOAD:
  - `beat_rdy` = 1.
  - Each accepted beat registers `wr_en`=4'hF, `wr_adr`={line,`cnt`}, `wr_dat`=`beat_dat`, then increments `cnt`.
  - Acceptance with `cnt`==BEATS-1 registers `rld_done`=1, wraps `cnt` to 0, and returns to IDLE.
- IDLE: `beat_rdy` = 0.
- `st_rdy` = !`hv`. An accepted store loads the hold register; it never writes in the acceptance cycle.
- Hold drain, where the array write registers in the drain cycle and `hv` clears:
  - IDLE: always drain.
  - RELOAD, store line ≠ reload line: drain in a cycle with no accepted beat. Beats have priority.
  - RELOAD, store line = reload line: wait until IDLE, unless merge is configured.
- Only one array write per cycle. `wr_en`=0 in any cycle with no write; `wr_adr`/`wr_dat` hold their last values.

## Timing
- Reset values: state IDLE, `cnt`=0, `hv`=0, `wr_en`=0, `wr_adr`=0, `wr_dat`=0, `rld_done`=0, `rld_busy`=0, `beat_rdy`=0, `st_rdy`=1.
- Beat accepted at edge N → `wr_*` valid during cycle N+1 → array written at edge N+2.
- Store accepted at edge N → drain earliest at edge N+1 → `wr_*` valid cycle N+2.
- Store throughput is at most one per 2 cycles. Reload throughput is one beat per cycle.
- `rld_busy` rises the cycle after `rld_start` and falls the cycle after the last beat is accepted.
- `rld_start` in the cycle RELOAD returns to IDLE is taken; the next reload begins one cycle later.
- Reset mid-reload aborts immediately:
  - The line is left partially written.
  - No `rld_done` pulse.
  - A held store is discarded.

## Configuration
- `DCDATA_WR_MERGE_EN` defined, same-line store during RELOAD, by store word `w` against `cnt`:
  - `w` < `cnt` (word already filled): drains in a no-beat cycle.
  - `w` == `cnt` with a beat accepted: one write, `wr_en`=4'hF. `wr_dat` takes the store byte where `st_be` is set and the beat byte otherwise; `hv` clears.
  - `w` > `cnt`: waits.
- `DCDATA_WR_MERGE_EN` undefined: a same-line store waits for IDLE and is written after the whole line.

## Test plan
- Reset → all outputs at reset values; `st_rdy`=1, `wr_en`=0.
- `rld_start` with line 7b'0000011, then 8 back-to-back beats 32'h10..32'h17 → writes to addresses 24..31 on consecutive cycles. `rld_done` pulses with the address-31 write; `rld_busy` falls on the next cycle.
- Idle store, `st_adr`=10'h155, `st_be`=4'b0101, `st_dat`=32'hAABBCCDD → exactly one write 2 cycles later: `wr_en`=4'b0101, `wr_adr`=10'h155; `st_rdy` low for one cycle.
- During a reload of line 3, store to address 100 while beats stall one cycle → store written in the stalled cycle; the beat sequence is unchanged.
- During a reload of line 3, store to address 26 with `st_be`=4'b0001, `st_dat`=32'h000000EE:
  - Merge off: single write of address 26 after `rld_done`.
  - Merge on: the beat-2 write carries byte 0 = 8'hEE and the remaining bytes from the beat.
- Assert `rst` after 3 beats → no `rld_done`, `wr_en`=0, state IDLE, held store dropped, `st_rdy`=1.
